// File: rtl/pkt_checker_pkg.sv
// Shared definitions for the packet checker: FSM state encoding, default header
// value and a word-extract helper usable for any bus/word geometry.
package pkt_checker_pkg;

    localparam int MAX_BUS_W  = 512;
    localparam int MAX_WORD_W = 64;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_FIRST_PKT = 3'd1,
        ST_REG_PKT   = 3'd2,
        ST_F_ERR     = 3'd3,
        ST_SEQ_ERR   = 3'd4
    } state_e;

    // Truncated to WORD_SIZE at the point of use, giving an all-ones header.
    localparam logic [MAX_WORD_W-1:0] HDR_DEFAULT = '1;

    function automatic logic [MAX_WORD_W-1:0] get_word(
        input logic [MAX_BUS_W-1:0] bus,
        input int                   idx,
        input int                   wsize
    );
        logic [MAX_BUS_W-1:0] mask;
        mask = {MAX_BUS_W{1'b1}} >> (MAX_BUS_W - wsize);
        return MAX_WORD_W'((bus >> (idx * wsize)) & mask);
    endfunction

endpackage

// File: rtl/pkt_word_check.sv
// Combinational per-packet qualification: header match, sequence match and
// a per-word non-zero mask.
module pkt_word_check
    import pkt_checker_pkg::*;
#(
    parameter int                   BUS_SIZE  = 16,
    parameter int                   WORD_SIZE = 4,
    parameter logic [WORD_SIZE-1:0] HEADER    = WORD_SIZE'(HDR_DEFAULT)
) (
    input  logic [BUS_SIZE-1:0]           data_input,
    input  logic [WORD_SIZE-1:0]          seq_exp,
    output logic                          hdr_ok,
    output logic                          seq_ok,
    output logic [BUS_SIZE/WORD_SIZE-1:0] word_nz
);

    localparam int WORD_NUM = BUS_SIZE / WORD_SIZE;

    logic [MAX_BUS_W-1:0] bus_ext;
    logic [WORD_SIZE-1:0] hdr_word;
    logic [WORD_SIZE-1:0] seq_word;

    assign bus_ext  = MAX_BUS_W'(data_input);
    assign hdr_word = WORD_SIZE'(get_word(bus_ext, WORD_NUM - 1, WORD_SIZE));
    assign seq_word = WORD_SIZE'(get_word(bus_ext, 0, WORD_SIZE));

    assign hdr_ok = (hdr_word == HEADER);
    assign seq_ok = (seq_word == seq_exp);

    always_comb begin
        word_nz = '0;
        for (int i = 0; i < WORD_NUM; i++) begin
            word_nz[i] = (WORD_SIZE'(get_word(bus_ext, i, WORD_SIZE)) != '0);
        end
    end

endmodule

// File: rtl/pkt_checker.sv
// Packet checker and forwarder: validates header/sequence of each valid beat,
// forwards accepted packets with a non-zero word mask, and counts failures.
module pkt_checker
    import pkt_checker_pkg::*;
#(
    parameter int                   BUS_SIZE  = 16,
    parameter int                   WORD_SIZE = 4,
    parameter logic [WORD_SIZE-1:0] HEADER    = WORD_SIZE'(HDR_DEFAULT),
    parameter bit                   RESYNC    = 1'b0,
    parameter int                   ERR_CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid_in,
    input  logic [BUS_SIZE-1:0]           data_input,
    output logic [BUS_SIZE-1:0]           data_out,
    output logic [BUS_SIZE/WORD_SIZE-1:0] output_control,
    output logic                          valid_out,
    output logic                          err,
    output logic                          nxt_err,
    output logic [2:0]                    state,
    output logic [ERR_CNT_W-1:0]          err_count
);

    localparam int WORD_NUM = BUS_SIZE / WORD_SIZE;

    state_e                 state_q, state_d;
    logic [WORD_SIZE-1:0]   seq_exp_q, seq_exp_d;
    logic [BUS_SIZE-1:0]    data_out_q, data_out_d;
    logic [WORD_NUM-1:0]    out_ctrl_q, out_ctrl_d;
    logic                   valid_out_q, valid_out_d;
    logic                   err_q, err_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic                   hdr_ok;
    logic                   seq_ok;
    logic [WORD_NUM-1:0]    word_nz;
    logic                   accept;
    logic                   fail;

    pkt_word_check #(
        .BUS_SIZE  (BUS_SIZE),
        .WORD_SIZE (WORD_SIZE),
        .HEADER    (HEADER)
    ) u_word_check (
        .data_input (data_input),
        .seq_exp    (seq_exp_q),
        .hdr_ok     (hdr_ok),
        .seq_ok     (seq_ok),
        .word_nz    (word_nz)
    );

    always_comb begin
        state_d     = state_q;
        seq_exp_d   = seq_exp_q;
        data_out_d  = data_out_q;
        out_ctrl_d  = out_ctrl_q;
        valid_out_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        accept      = 1'b0;
        fail        = 1'b0;

        unique case (state_q)
            ST_RESET: begin
                state_d = ST_FIRST_PKT;
            end
            ST_FIRST_PKT, ST_REG_PKT: begin
                if (valid_in) begin
                    if (!hdr_ok) begin
                        state_d = ST_F_ERR;
                        fail    = 1'b1;
                    end else if (!seq_ok) begin
                        state_d = ST_SEQ_ERR;
                        fail    = 1'b1;
                    end else begin
                        accept = 1'b1;
                    end
                end
            end
            ST_F_ERR, ST_SEQ_ERR: begin
                if (valid_in) begin
                    if (RESYNC) begin
                        // A good header re-anchors the sequence on the received number.
                        if (hdr_ok) begin
                            accept    = 1'b1;
                            seq_exp_d = data_input[WORD_SIZE-1:0];
                        end else begin
                            state_d = ST_F_ERR;
                            fail    = 1'b1;
                        end
                    end else begin
                        fail = !hdr_ok || !seq_ok;
                    end
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase

        if (accept) begin
            state_d     = ST_REG_PKT;
            seq_exp_d   = seq_exp_d + 1'b1;
            data_out_d  = data_input;
            out_ctrl_d  = word_nz;
            valid_out_d = 1'b1;
        end

        if (fail && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end

        err_d = (state_d == ST_F_ERR) || (state_d == ST_SEQ_ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RESET;
            seq_exp_q   <= '0;
            data_out_q  <= '0;
            out_ctrl_q  <= '0;
            valid_out_q <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            seq_exp_q   <= seq_exp_d;
            data_out_q  <= data_out_d;
            out_ctrl_q  <= out_ctrl_d;
            valid_out_q <= valid_out_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign nxt_err        = reset ? 1'b0 : err_d;
    assign data_out       = data_out_q;
    assign output_control = out_ctrl_q;
    assign valid_out      = valid_out_q;
    assign err            = err_q;
    assign state          = state_q;
    assign err_count      = err_cnt_q;

endmodule
